// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - sequential ROM fetch stage with wait states, prefetch FIFO and redirect flush
module rom_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          WAIT_CYCLES = 1,
   parameter int          FIFO_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_address,
   output logic        rom_chip_select,
   output logic        rom_output_enable,
   input  logic [63:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [63:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int               PTR_W     = $clog2(FIFO_DEPTH);
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [3:0]       LAST_WAIT = 4'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_rom_address;
   logic             r_cs;
   logic [3:0]       r_wait_cnt;
   logic [63:0]      r_mem_data [FIFO_DEPTH];
   logic [31:0]      r_mem_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_inst_valid;
   logic [63:0]      r_inst_data;
   logic [31:0]      r_inst_pc;

   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count_next;
   logic [PTR_W-1:0] w_rd_ptr_next;
   logic             w_head_fresh;
   logic             w_full;
   logic [31:0]      w_pc_inc;

   // Redirect suppresses both push and pop so the flush is the only thing that happens that edge
   assign w_push        = (r_state == ACCESS) && (r_wait_cnt == LAST_WAIT) && !redirect_valid;
   assign w_pop         = r_inst_valid && inst_ready && !redirect_valid;
   assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_rd_ptr_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
   // The new head is the word being pushed right now when it lands in the slot the read pointer moves to
   assign w_head_fresh  = w_push && (w_rd_ptr_next == r_wr_ptr);
   assign w_full        = (r_count == DEPTH_C);
   assign w_pc_inc      = r_pc + 32'd1;

   assign rom_address       = r_rom_address;
   assign rom_chip_select   = r_cs;
   assign rom_output_enable = r_cs;
   assign inst_valid        = r_inst_valid;
   assign inst_data         = r_inst_data;
   assign inst_pc           = r_inst_pc;

   // FIFO storage: written on push only; occupancy decides which entries are meaningful
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= rom_data;
         r_mem_pc[r_wr_ptr]   <= r_pc;
      end
   end

   // FIFO pointers, occupancy and the registered head presented to the consumer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_inst_valid <= 1'b0;
         r_inst_data  <= '0;
         r_inst_pc    <= '0;
      end else if (redirect_valid) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_inst_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr     <= w_rd_ptr_next;
         r_count      <= w_count_next;
         r_inst_valid <= (w_count_next != '0);
         if (w_count_next != '0) begin
            r_inst_data <= w_head_fresh ? rom_data : r_mem_data[w_rd_ptr_next];
            r_inst_pc   <= w_head_fresh ? r_pc     : r_mem_pc[w_rd_ptr_next];
         end
      end
   end

   // Access sequencer: holds the ROM bus stable for WAIT_CYCLES, then advances pc or parks when full
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_pc          <= RESET_PC;
         r_rom_address <= RESET_PC;
         r_cs          <= 1'b0;
         r_wait_cnt    <= '0;
      end else if (redirect_valid) begin
         r_state       <= IDLE;
         r_pc          <= redirect_pc;
         r_rom_address <= redirect_pc;
         r_cs          <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_full) begin
                  r_state       <= ACCESS;
                  r_rom_address <= r_pc;
                  r_cs          <= 1'b1;
                  r_wait_cnt    <= '0;
               end
            end
            ACCESS: begin
               if (w_push) begin
                  r_pc          <= w_pc_inc;
                  r_rom_address <= w_pc_inc;
                  r_wait_cnt    <= '0;
                  if (w_count_next == DEPTH_C) begin
                     r_state <= IDLE;
                     r_cs    <= 1'b0;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cs    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb/tb_rom_fetch_unit.sv - randomized scoreboard bench for two rom_fetch_unit configurations
module tb_rom_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_address    [2];
   logic        rom_cs         [2];
   logic        rom_oe         [2];
   logic [63:0] rom_data       [2];
   logic        redirect_valid [2];
   logic [31:0] redirect_pc    [2];
   logic        inst_valid     [2];
   logic        inst_ready     [2];
   logic [63:0] inst_data      [2];
   logic [31:0] inst_pc        [2];

   logic [31:0] exp_pc [2];
   int          pops   [2];
   int          run    [2];
   int          n_compared;
   int          n_mismatched;

   always #5 clk = ~clk;

   function automatic int wait_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] rst_pc_of(input int i);
      return (i == 0) ? 32'h0 : 32'hA;
   endfunction

   function automatic logic [63:0] rom_word(input logic [31:0] a);
      case (a)
         32'hD:   return 64'hFFFF;
         32'hE:   return 64'h1234;
         32'hF:   return 64'hABCD;
         default: return (a < 32'hD) ? 64'(a) * 64'h1111 : 64'h0;
      endcase
   endfunction

   // ROM behavioural model: drives junk when not enabled so unenabled sampling shows up
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rom_data[i] = rom_cs[i] ? rom_word(rom_address[i]) : 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   rom_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(1), .FIFO_DEPTH(2)) u_dut_w1 (
      .clk(clk), .reset(rst),
      .rom_address(rom_address[0]), .rom_chip_select(rom_cs[0]), .rom_output_enable(rom_oe[0]),
      .rom_data(rom_data[0]),
      .redirect_valid(redirect_valid[0]), .redirect_pc(redirect_pc[0]),
      .inst_valid(inst_valid[0]), .inst_ready(inst_ready[0]),
      .inst_data(inst_data[0]), .inst_pc(inst_pc[0])
   );

   rom_fetch_unit #(.RESET_PC(32'hA), .WAIT_CYCLES(3), .FIFO_DEPTH(2)) u_dut_w3 (
      .clk(clk), .reset(rst),
      .rom_address(rom_address[1]), .rom_chip_select(rom_cs[1]), .rom_output_enable(rom_oe[1]),
      .rom_data(rom_data[1]),
      .redirect_valid(redirect_valid[1]), .redirect_pc(redirect_pc[1]),
      .inst_valid(inst_valid[1]), .inst_ready(inst_ready[1]),
      .inst_data(inst_data[1]), .inst_pc(inst_pc[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s_cs%0d", tag, i), rom_cs[i], 1'b0);
         check_eq($sformatf("%s_oe%0d", tag, i), rom_oe[i], 1'b0);
         check_eq($sformatf("%s_addr%0d", tag, i), rom_address[i], rst_pc_of(i));
         check_eq($sformatf("%s_valid%0d", tag, i), inst_valid[i], 1'b0);
         check_eq($sformatf("%s_ipc%0d", tag, i), inst_pc[i], 32'h0);
         check_eq($sformatf("%s_idata%0d", tag, i), inst_data[i], 64'h0);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         exp_pc[i] = rst_pc_of(i);
         run[i]    = 0;
      end
   endtask

   // One clock: score pops against the in-order pc stream, then check bus protocol after the edge
   task automatic step();
      logic        pre_cs    [2];
      logic [31:0] pre_addr  [2];
      logic        pre_redir [2];
      for (int i = 0; i < 2; i++) begin
         pre_cs[i]    = rom_cs[i];
         pre_addr[i]  = rom_address[i];
         pre_redir[i] = redirect_valid[i];
         if (redirect_valid[i]) begin
            exp_pc[i] = redirect_pc[i];
         end else if (inst_valid[i] && inst_ready[i]) begin
            check_eq($sformatf("pop%0d_pc", i), inst_pc[i], exp_pc[i]);
            check_eq($sformatf("pop%0d_data", i), inst_data[i], rom_word(exp_pc[i]));
            exp_pc[i] = exp_pc[i] + 32'd1;
            pops[i]++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("oe_eq_cs%0d", i), rom_oe[i], rom_cs[i]);
         if (pre_redir[i]) begin
            check_eq($sformatf("redir_flush_valid%0d", i), inst_valid[i], 1'b0);
            check_eq($sformatf("redir_flush_cs%0d", i), rom_cs[i], 1'b0);
         end
         if (pre_cs[i] && !(rom_cs[i] && rom_address[i] == pre_addr[i]) && !pre_redir[i]) begin
            check_eq($sformatf("access_len%0d", i), 64'(run[i]), 64'(wait_of(i)));
         end
         if (rom_cs[i]) begin
            run[i] = (pre_cs[i] && rom_address[i] == pre_addr[i]) ? run[i] + 1 : 1;
         end else begin
            run[i] = 0;
         end
      end
   endtask

   task automatic wait_pops(input int i, input int n, input int budget, input string tag);
      int target;
      target = pops[i] + n;
      for (int k = 0; k < budget && pops[i] < target; k++) begin
         step();
      end
      check_eq(tag, pops[i] >= target, 1'b1);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst          = 1'b1;
      for (int i = 0; i < 2; i++) begin
         redirect_valid[i] = 1'b0;
         redirect_pc[i]    = 32'h0;
         inst_ready[i]     = 1'b0;
         pops[i]           = 0;
      end
      model_reset();
      inst_ready[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Latency and streaming: cycle 1 is the first rising edge after release
      step();
      check_eq("c1_cs0", rom_cs[0], 1'b1);
      check_eq("c1_addr0", rom_address[0], 32'h0);
      check_eq("c1_valid0", inst_valid[0], 1'b0);
      check_eq("c1_cs1", rom_cs[1], 1'b1);
      check_eq("c1_addr1", rom_address[1], 32'hA);
      step();
      check_eq("c2_valid0", inst_valid[0], 1'b1);
      check_eq("c2_pc0", inst_pc[0], 32'h0);
      check_eq("c2_valid1", inst_valid[1], 1'b0);
      for (int c = 3; c <= 30; c++) begin
         if (c == 6) begin
            redirect_valid[1] = 1'b1;
            redirect_pc[1]    = 32'hD;
         end
         step();
         redirect_valid[1] = 1'b0;
         if (c == 4) begin
            check_eq("c4_valid1", inst_valid[1], 1'b1);
            check_eq("c4_cs1", rom_cs[1], 1'b1);
            check_eq("c4_addr1", rom_address[1], 32'hB);
            check_eq("c4_pc1", inst_pc[1], 32'hA);
         end
         if (c == 6) begin
            check_eq("c6_valid1", inst_valid[1], 1'b0);
            check_eq("c6_cs1", rom_cs[1], 1'b0);
            inst_ready[1] = 1'b1;
         end
         if (c == 18) check_eq("w1_throughput", pops[0], 16);
      end
      check_eq("w3_throughput", pops[1], 7);

      // Asynchronous reset in the middle of an access
      check_eq("pre_reset_cs1", rom_cs[1], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      inst_ready[0] = 1'b0;
      inst_ready[1] = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Backpressure: exactly two words fetched, then parked at pc 2
      repeat (6) step();
      check_eq("full_cs0", rom_cs[0], 1'b0);
      check_eq("full_addr0", rom_address[0], 32'h2);
      check_eq("full_valid0", inst_valid[0], 1'b1);
      check_eq("full_pc0", inst_pc[0], 32'h0);
      inst_ready[0] = 1'b1;
      step();
      inst_ready[0] = 1'b0;
      check_eq("after_pop_pc0", inst_pc[0], 32'h1);
      check_eq("after_pop_data0", inst_data[0], 64'h1111);
      for (int k = 0; k < 4 && !rom_cs[0]; k++) step();
      check_eq("refetch_cs0", rom_cs[0], 1'b1);
      check_eq("refetch_addr0", rom_address[0], 32'h2);
      repeat (4) step();

      // Redirects across the 32-bit wrap
      inst_ready[0]     = 1'b1;
      redirect_valid[0] = 1'b1;
      redirect_pc[0]    = 32'hFFFF_FFFF;
      redirect_valid[1] = 1'b1;
      redirect_pc[1]    = 32'hFFFF_FFFE;
      step();
      redirect_valid[0] = 1'b0;
      redirect_valid[1] = 1'b0;
      wait_pops(0, 3, 30, "wrap_pops0");
      wait_pops(1, 4, 60, "wrap_pops1");

      // Randomized traffic with back-pressure and occasional (sometimes back-to-back) redirects
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            inst_ready[i]     = ($urandom % 4) != 0;
            redirect_valid[i] = ($urandom % 40) == 0;
            case ($urandom % 3)
               0:       redirect_pc[i] = $urandom_range(0, 31);
               1:       redirect_pc[i] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
               default: redirect_pc[i] = $urandom;
            endcase
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         redirect_valid[i] = 1'b0;
         inst_ready[i]     = 1'b1;
      end
      wait_pops(0, 2, 20, "drain_pops0");
      wait_pops(1, 2, 20, "drain_pops1");
      check_eq("total_pops0", pops[0] > 400, 1'b1);
      check_eq("total_pops1", pops[1] > 200, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
